// File: rtl/ms_serial_pkg.sv
// rtl/ms_serial_pkg.sv - shared types and sizing helpers for the digit-serial multiplier
package ms_serial_pkg;

  typedef enum logic [1:0] {IDLE, MUL, FIX} state_t;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  function automatic int digits_f(input int w, input int b);
    return ceil_div(w, b);
  endfunction

  function automatic int out_w_f(input int w, input int n);
    return w * n;
  endfunction

endpackage

// File: rtl/ms_digit_mac.sv
// rtl/ms_digit_mac.sv - one digit step: part_next = (part << B) + acc * digit
module ms_digit_mac #(
  parameter int OUT_W = 10,
  parameter int B     = 4
) (
  input  logic [OUT_W-1:0] part,
  input  logic [OUT_W-1:0] acc,
  input  logic [B-1:0]     digit,
  output logic [OUT_W-1:0] part_next
);

  logic [OUT_W-1:0] w_digit_ext;

  assign w_digit_ext = {{(OUT_W-B){1'b0}}, digit};
  assign part_next   = (part << B) + acc * w_digit_ext;

endmodule

// File: rtl/ms_serial_digit_mul.sv
// rtl/ms_serial_digit_mul.sv - MSD-first digit-serial multi-operand multiplier with start/busy/done
module ms_serial_digit_mul
  import ms_serial_pkg::*;
#(
  parameter int DATA_WIDTH = 5,
  parameter int NUM_INPUTS = 2,
  parameter int DIGIT_BITS = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             en,
  input  logic                             start,
  input  logic                             signed_mode,
  input  logic [DATA_WIDTH-1:0]            bin_data_in [NUM_INPUTS],
  output logic [DATA_WIDTH*NUM_INPUTS-1:0] bin_data_out,
  output logic                             busy,
  output logic                             done
);

  localparam int W      = DATA_WIDTH;
  localparam int N      = NUM_INPUTS;
  localparam int B      = DIGIT_BITS;
  localparam int DIGITS = digits_f(W, B);
  localparam int OUT_W  = out_w_f(W, N);
  localparam int MAG_W  = DIGITS * B;
  localparam int OP_W   = $clog2(N);
  localparam int DIG_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [DIG_W-1:0] DIG_LAST = DIG_W'(DIGITS - 1);
  localparam logic [OP_W-1:0]  OP_LAST  = OP_W'(N - 1);

  // Magnitude of a W-bit operand; the signed minimum still fits unsigned W bits.
  function automatic logic [MAG_W-1:0] mag_f(input logic [W-1:0] x, input logic sgn);
    logic [W-1:0] m;
    m = (sgn && x[W-1]) ? (~x + 1'b1) : x;
    return MAG_W'(m);
  endfunction

  state_t           r_state;
  logic [MAG_W-1:0] r_mag [N];
  logic [OUT_W-1:0] r_acc;
  logic [OUT_W-1:0] r_part;
  logic [OP_W-1:0]  r_op;
  logic [DIG_W-1:0] r_dig;
  logic             r_sign;
  logic [OUT_W-1:0] r_out;
  logic             r_busy;
  logic             r_done;

  logic [B-1:0]     w_digit;
  logic [OUT_W-1:0] w_part_next;
  logic             w_par;

  always_comb begin
    w_par = 1'b0;
    for (int k = 0; k < N; k++) w_par = w_par ^ bin_data_in[k][W-1];
  end

  assign w_digit = r_mag[r_op][r_dig*B +: B];

  ms_digit_mac #(.OUT_W(OUT_W), .B(B)) u_mac (
    .part      (r_part),
    .acc       (r_acc),
    .digit     (w_digit),
    .part_next (w_part_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      for (int k = 0; k < N; k++) r_mag[k] <= '0;
      r_acc   <= '0;
      r_part  <= '0;
      r_op    <= '0;
      r_dig   <= '0;
      r_sign  <= 1'b0;
      r_out   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else if (en) begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            for (int k = 0; k < N; k++) r_mag[k] <= mag_f(bin_data_in[k], signed_mode);
            r_acc   <= OUT_W'(mag_f(bin_data_in[0], signed_mode));
            r_sign  <= signed_mode & w_par;
            r_op    <= OP_W'(1);
            r_dig   <= DIG_LAST;
            r_part  <= '0;
            r_busy  <= 1'b1;
            r_state <= MUL;
          end
        end
        MUL: begin
          // Last digit of this operand: the finished partial becomes the new multiplicand.
          if (r_dig == '0) begin
            r_acc  <= w_part_next;
            r_part <= '0;
            r_dig  <= DIG_LAST;
            r_op   <= r_op + 1'b1;
            if (r_op == OP_LAST) r_state <= FIX;
          end else begin
            r_part <= w_part_next;
            r_dig  <= r_dig - 1'b1;
          end
        end
        FIX: begin
          r_out   <= r_sign ? -r_acc : r_acc;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bin_data_out = r_out;
  assign busy         = r_busy;
  assign done         = r_done;

endmodule

// File: tb/tb_ms_serial_digit_mul.sv
// tb/tb_ms_serial_digit_mul.sv - directed self-checking bench for ms_serial_digit_mul
module tb_ms_serial_digit_mul;

  logic        clk;
  logic        rst;
  logic        en;
  logic        start;
  logic        sm;
  logic [4:0]  din [2];
  logic [9:0]  dout;
  logic        busy;
  logic        done;

  logic        start_b;
  logic        sm_b;
  logic [4:0]  din_b [3];
  logic [14:0] dout_b;
  logic        busy_b;
  logic        done_b;

  int passed;
  int total;

  ms_serial_digit_mul #(.DATA_WIDTH(5), .NUM_INPUTS(2), .DIGIT_BITS(4)) dut (
    .clk(clk), .rst(rst), .en(en), .start(start), .signed_mode(sm),
    .bin_data_in(din), .bin_data_out(dout), .busy(busy), .done(done)
  );

  ms_serial_digit_mul #(.DATA_WIDTH(5), .NUM_INPUTS(3), .DIGIT_BITS(2)) dut_b (
    .clk(clk), .rst(rst), .en(en), .start(start_b), .signed_mode(sm_b),
    .bin_data_in(din_b), .bin_data_out(dout_b), .busy(busy_b), .done(done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Caller is positioned 1 time unit after an edge.
  task automatic do_mul(input logic [4:0] a, input logic [4:0] b, input logic s,
                        input logic [9:0] exp, input string nm);
    int cyc;
    int bcnt;
    din[0] = a; din[1] = b; sm = s; start = 1'b1;
    step();
    start = 1'b0;
    cyc = 0; bcnt = 0;
    while (!done && cyc < 20) begin
      bcnt += int'(busy);
      step();
      cyc++;
    end
    total++; if (cyc !== 3) $display("FAIL %s latency: got %0d expected 3", nm, cyc); else passed++;
    total++; if (dout !== exp) $display("FAIL %s out: got %0h expected %0h", nm, dout, exp); else passed++;
    total++; if (bcnt !== 3) $display("FAIL %s busy_cycles: got %0d expected 3", nm, bcnt); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL %s busy_at_done: got %b expected 0", nm, busy); else passed++;
    step();
    total++; if (done !== 1'b0) $display("FAIL %s done_pulse: got %b expected 0", nm, done); else passed++;
  endtask

  task automatic do_mul3(input logic [4:0] a, input logic [4:0] b, input logic [4:0] c,
                         input logic s, input logic [14:0] exp, input string nm);
    int cyc;
    din_b[0] = a; din_b[1] = b; din_b[2] = c; sm_b = s; start_b = 1'b1;
    step();
    start_b = 1'b0;
    cyc = 0;
    while (!done_b && cyc < 30) begin
      step();
      cyc++;
    end
    total++; if (cyc !== 7) $display("FAIL %s latency: got %0d expected 7", nm, cyc); else passed++;
    total++; if (dout_b !== exp) $display("FAIL %s out: got %0d expected %0d", nm, dout_b, exp); else passed++;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; start = 1'b0; start_b = 1'b0; sm = 1'b0; sm_b = 1'b0;
    din[0] = '0; din[1] = '0;
    for (int k = 0; k < 3; k++) din_b[k] = '0;
    step(); step();
    rst = 1'b0;
    total++; if (dout !== 10'd0) $display("FAIL reset_out: got %0d expected 0", dout); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else passed++;
    total++; if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done); else passed++;
    total++; if (dout_b !== 15'd0) $display("FAIL reset_out_b: got %0d expected 0", dout_b); else passed++;
  endtask

  task automatic test_unsigned();
    do_mul(5'd13, 5'd7, 1'b0, 10'd91, "u13x7");
    do_mul(5'd31, 5'd31, 1'b0, 10'd961, "u31x31");
    do_mul(5'h1D, 5'd7, 1'b0, 10'd203, "u29x7");
  endtask

  task automatic test_signed();
    do_mul(5'h1D, 5'h07, 1'b1, 10'h3EB, "s_m3x7");
    do_mul(5'h10, 5'h10, 1'b1, 10'd256, "s_m16xm16");
    do_mul(5'h10, 5'h0F, 1'b1, 10'h310, "s_m16x15");
  endtask

  task automatic test_three_ops();
    do_mul3(5'd31, 5'd31, 5'd31, 1'b0, 15'd29791, "n3_31cubed");
    do_mul3(5'h10, 5'h10, 5'h10, 1'b1, 15'd28672, "n3_m16cubed");
    do_mul3(5'h1F, 5'h1F, 5'h1F, 1'b1, 15'h7FFF, "n3_m1cubed");
  endtask

  task automatic test_enable();
    int en_cnt;
    int cyc;
    din[0] = 5'd13; din[1] = 5'd7; sm = 1'b0; start = 1'b1; en = 1'b1;
    step();
    start = 1'b0;
    en_cnt = 0; cyc = 0;
    while (!done && cyc < 40) begin
      en = ~en;
      step();
      if (en) en_cnt++;
      cyc++;
    end
    total++; if (en_cnt !== 3) $display("FAIL en_latency: got %0d expected 3", en_cnt); else passed++;
    total++; if (dout !== 10'd91) $display("FAIL en_out: got %0d expected 91", dout); else passed++;
    en = 1'b0;
    step(); step();
    total++; if (done !== 1'b1) $display("FAIL en_done_held: got %b expected 1", done); else passed++;
    en = 1'b1;
    step();
    total++; if (done !== 1'b0) $display("FAIL en_done_drop: got %b expected 0", done); else passed++;
  endtask

  task automatic test_reset_mid();
    int seen;
    din[0] = 5'd13; din[1] = 5'd7; sm = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++; if (busy !== 1'b0) $display("FAIL rstmid_busy: got %b expected 0", busy); else passed++;
    total++; if (dout !== 10'd0) $display("FAIL rstmid_out: got %0d expected 0", dout); else passed++;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      seen += int'(done);
      step();
    end
    total++; if (seen !== 0) $display("FAIL rstmid_no_done: got %0d expected 0", seen); else passed++;
    do_mul(5'd3, 5'd5, 1'b0, 10'd15, "rstmid_after");
  endtask

  task automatic test_back_to_back();
    int cyc;
    din[0] = 5'd13; din[1] = 5'd7; sm = 1'b0; start = 1'b1;
    step();
    din[0] = 5'd1; din[1] = 5'd1;
    cyc = 0;
    while (!done && cyc < 20) begin
      step();
      cyc++;
    end
    total++; if (cyc !== 3) $display("FAIL b2b_latency1: got %0d expected 3", cyc); else passed++;
    total++; if (dout !== 10'd91) $display("FAIL b2b_out1: got %0d expected 91", dout); else passed++;
    din[0] = 5'd3; din[1] = 5'd3;
    step();
    start = 1'b0; din[0] = 5'd0; din[1] = 5'd0;
    total++; if (busy !== 1'b1) $display("FAIL b2b_accept_busy: got %b expected 1", busy); else passed++;
    total++; if (done !== 1'b0) $display("FAIL b2b_accept_done: got %b expected 0", done); else passed++;
    cyc = 0;
    while (!done && cyc < 20) begin
      step();
      cyc++;
    end
    total++; if (cyc !== 3) $display("FAIL b2b_latency2: got %0d expected 3", cyc); else passed++;
    total++; if (dout !== 10'd9) $display("FAIL b2b_out2: got %0d expected 9", dout); else passed++;
    step();
  endtask

  initial begin
    passed = 0;
    total = 0;
    test_reset();
    test_unsigned();
    test_signed();
    test_three_ops();
    test_enable();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
